mdio_responder: RTL and testbench

- Clause-22 MDIO management responder, i.e. the PHY side of the MDC/MDIO link.
- Oversamples MDC/MDIO on the 50 MHz system clock and decodes write and read frames addressed to its PHY address.
- Writes come out as register strobes; reads are answered by driving MDIO with data fetched over a simple register port.
- Used as a PHY register model behind our PHY configuration master and for on-board PHY emulation.

---
 rtl/mdio_pkg.sv | 35 +++
 rtl/mdio_sync_edge.sv | 45 ++++
 rtl/mdio_responder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, field widths and FSM state type for the Clause-22 MDIO responder.
package mdio_pkg;

   // Frame codes, MSB first on the wire
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] ST_CODE  = 2'b01;

   // Field widths
   localparam int unsigned PHYAD_W = 5;
   localparam int unsigned REGAD_W = 5;
   localparam int unsigned DATA_W  = 16;

   // Bits let pass by a frame for another PHY: two TA bits plus the data field
   localparam int unsigned SKIP_BITS = 2 + DATA_W;

   typedef enum logic [3:0] {
      IDLE,
      ST,
      OP,
      PHYAD,
      REGAD,
      SKIP,
      TA_W,
      WDATA,
      TA_R,
      RDATA
   } mdio_state_e;

   // Only write and read opcodes are legal in Clause 22
   function automatic logic op_valid(input logic [1:0] op);
      return (op == OP_WRITE) || (op == OP_READ);
   endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Synchronises MDC and MDIO into the clock_50m domain and detects MDC edges.
// mdio_s is delayed by the same number of stages as mdc, so it lines up with mdc_rise.
module mdio_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock_50m,
   input  logic reset,
   input  logic mdc,
   input  logic mdio_i,
   output logic mdc_rise,
   output logic mdc_fall,
   output logic mdio_s
);

   logic [SYNC_STAGES-1:0] mdc_sync_q;
   logic [SYNC_STAGES-1:0] mdio_sync_q;
   logic                   mdc_prev_q;
   logic                   mdc_s;

   // Synchroniser chains plus one extra MDC sample for edge detection
   always_ff @(posedge clock_50m or posedge reset) begin
      if (reset) begin
         mdc_sync_q  <= '0;
         mdio_sync_q <= '1;
         mdc_prev_q  <= 1'b0;
      end else begin
         mdc_sync_q[0]  <= mdc;
         mdio_sync_q[0] <= mdio_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            mdc_sync_q[i]  <= mdc_sync_q[i-1];
            mdio_sync_q[i] <= mdio_sync_q[i-1];
         end
         mdc_prev_q <= mdc_sync_q[SYNC_STAGES-1];
      end
   end

   // Edge pulses from previous vs current synchronised MDC; never both at once
   always_comb begin
      mdc_s    = mdc_sync_q[SYNC_STAGES-1];
      mdc_rise = mdc_s & ~mdc_prev_q;
      mdc_fall = ~mdc_s & mdc_prev_q;
      mdio_s   = mdio_sync_q[SYNC_STAGES-1];
   end

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side). Decodes write/read frames addressed to
// PHY_ADDR, emits register strobes and answers reads by driving MDIO.
// Optional: define MDIO_BROADCAST_EN to also accept writes addressed to PHYAD 0.
module mdio_responder
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter int unsigned PREAMBLE_MIN = 32,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        clock_50m,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [4:0]  reg_addr,
   output logic [15:0] reg_wdata,
   input  logic [15:0] reg_rdata,
   output logic        frame_err
);

   localparam int unsigned         PRE_W   = $clog2(PREAMBLE_MIN + 1);
   localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(PREAMBLE_MIN);

   // Bit counter end values per field
   localparam logic [4:0] CNT_OP_LAST    = 5'd1;
   localparam logic [4:0] CNT_PHYAD_LAST = 5'(PHYAD_W - 1);
   localparam logic [4:0] CNT_REGAD_LAST = 5'(REGAD_W - 1);
   localparam logic [4:0] CNT_DATA_LAST  = 5'(DATA_W - 1);
   localparam logic [4:0] CNT_SKIP_LAST  = 5'(SKIP_BITS - 1);
   localparam logic [4:0] CNT_RDATA_END  = 5'(DATA_W);

   logic mdc_rise;
   logic mdc_fall;
   logic mdio_s;

   mdio_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clock_50m(clock_50m),
      .reset    (reset),
      .mdc      (mdc),
      .mdio_i   (mdio_i),
      .mdc_rise (mdc_rise),
      .mdc_fall (mdc_fall),
      .mdio_s   (mdio_s)
   );

   mdio_state_e          state_q;
   logic [PRE_W-1:0]     pre_cnt_q;
   logic [4:0]           bit_cnt_q;
   logic [1:0]           op_q;
   logic [PHYAD_W-1:0]   phyad_q;
   logic [REGAD_W-1:0]   regad_q;
   logic [DATA_W-1:0]    shift_q;
   logic                 ta_seen_q;

   logic                 sample_en;
   logic                 rx_bit;
   logic [1:0]           op_next;
   logic [PHYAD_W-1:0]   phyad_next;
   logic [REGAD_W-1:0]   regad_next;
   logic [DATA_W-1:0]    wdata_next;
   logic                 rd_hit;
   logic                 wr_hit;

   // Bit sampling on MDC rise, ignored while we own the pad; shift-in helpers
   always_comb begin
      sample_en  = mdc_rise & ~mdio_oe;
      rx_bit     = mdio_s;
      op_next    = {op_q[0], rx_bit};
      phyad_next = {phyad_q[PHYAD_W-2:0], rx_bit};
      regad_next = {regad_q[REGAD_W-2:0], rx_bit};
      wdata_next = {shift_q[DATA_W-2:0], rx_bit};
   end

   // Address match: reads only for our own address, writes optionally also for PHYAD 0
   always_comb begin
      rd_hit = (phyad_q == PHY_ADDR);
      wr_hit = rd_hit;
`ifdef MDIO_BROADCAST_EN
      wr_hit = rd_hit | (phyad_q == '0);
`endif
   end

   // Frame FSM with registered pad and register-port outputs
   always_ff @(posedge clock_50m or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pre_cnt_q <= '0;
         bit_cnt_q <= '0;
         op_q      <= '0;
         phyad_q   <= '0;
         regad_q   <= '0;
         shift_q   <= '0;
         ta_seen_q <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         frame_err <= 1'b0;
      end else begin
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;

         case (state_q)
            IDLE: begin
               if (sample_en) begin
                  if (rx_bit != ST_CODE[1]) begin
                     if (pre_cnt_q != PRE_MAX) begin
                        pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                     end
                  end else if (pre_cnt_q == PRE_MAX) begin
                     // Counter is cleared here so it restarts from 0 once the frame ends
                     pre_cnt_q <= '0;
                     state_q   <= ST;
                  end else begin
                     pre_cnt_q <= '0;
                  end
               end
            end

            ST: begin
               if (sample_en) begin
                  if (rx_bit == ST_CODE[0]) begin
                     bit_cnt_q <= '0;
                     state_q   <= OP;
                  end else begin
                     frame_err <= 1'b1;
                     state_q   <= IDLE;
                  end
               end
            end

            OP: begin
               if (sample_en) begin
                  op_q <= op_next;
                  if (bit_cnt_q == CNT_OP_LAST) begin
                     bit_cnt_q <= '0;
                     if (op_valid(op_next)) begin
                        state_q <= PHYAD;
                     end else begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end

            PHYAD: begin
               if (sample_en) begin
                  phyad_q <= phyad_next;
                  if (bit_cnt_q == CNT_PHYAD_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= REGAD;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end

            REGAD: begin
               if (sample_en) begin
                  regad_q <= regad_next;
                  if (bit_cnt_q == CNT_REGAD_LAST) begin
                     bit_cnt_q <= '0;
                     if (op_q == OP_READ) begin
                        if (rd_hit) begin
                           // Request read data early: a full MDC period passes before it is latched
                           reg_addr  <= regad_next;
                           reg_rd    <= 1'b1;
                           ta_seen_q <= 1'b0;
                           state_q   <= TA_R;
                        end else begin
                           state_q <= SKIP;
                        end
                     end else if (wr_hit) begin
                        state_q <= TA_W;
                     end else begin
                        state_q <= SKIP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end

            SKIP: begin
               if (sample_en) begin
                  if (bit_cnt_q == CNT_SKIP_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end

            TA_W: begin
               if (sample_en) begin
                  if (bit_cnt_q == 5'd0) begin
                     if (rx_bit) begin
                        bit_cnt_q <= 5'd1;
                     end else begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                     end
                  end else begin
                     bit_cnt_q <= '0;
                     if (!rx_bit) begin
                        state_q <= WDATA;
                     end else begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                     end
                  end
               end
            end

            WDATA: begin
               if (sample_en) begin
                  shift_q <= wdata_next;
                  if (bit_cnt_q == CNT_DATA_LAST) begin
                     bit_cnt_q <= '0;
                     reg_addr  <= regad_q;
                     reg_wdata <= wdata_next;
                     reg_wr    <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end

            TA_R: begin
               // First TA bit stays high-Z; we take the pad for the second TA bit
               if (mdc_rise) begin
                  ta_seen_q <= 1'b1;
               end else if (mdc_fall && ta_seen_q) begin
                  shift_q   <= reg_rdata;
                  mdio_oe   <= 1'b1;
                  mdio_o    <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= RDATA;
               end
            end

            RDATA: begin
               if (mdc_fall) begin
                  if (bit_cnt_q == CNT_RDATA_END) begin
                     mdio_oe   <= 1'b0;
                     mdio_o    <= 1'b1;
                     bit_cnt_q <= '0;
                     state_q   <= IDLE;
                  end else begin
                     mdio_o    <= shift_q[DATA_W-1];
                     shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a station model drives MDC/MDIO frames, a frame-level
// reference model predicts write/read/error/ignore outcomes.
module tb_mdio_responder;

   localparam logic [4:0] MY_ADDR = 5'd1;
   localparam int         HALF    = 8;
   localparam int         OE_READ = 17 * 2 * HALF;
   localparam int         K_NONE  = 0;
   localparam int         K_WR    = 1;
   localparam int         K_RD    = 2;
   localparam int         K_ERR   = 3;
`ifdef MDIO_BROADCAST_EN
   localparam bit BCAST = 1'b1;
`else
   localparam bit BCAST = 1'b0;
`endif

   logic        clock_50m = 1'b0;
   logic        reset     = 1'b1;
   logic        mdc       = 1'b0;
   logic        st_oe     = 1'b1;
   logic        st_val    = 1'b1;
   logic        mdio_pad;
   logic        mdio_o;
   logic        mdio_oe;
   logic        reg_wr;
   logic        reg_rd;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata = 16'h0000;
   logic        frame_err;

   int total = 0;
   int bad   = 0;

   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          err_cnt = 0;
   int          oe_cycles = 0;
   logic [4:0]  last_waddr = '0;
   logic [15:0] last_wdata = '0;
   logic [4:0]  last_raddr = '0;
   logic        oe_before;
   logic        oe_after;
   logic        o_after;

   // Open-drain style bus with pull-up: DUT wins when enabled, else station, else 1
   assign mdio_pad = mdio_oe ? mdio_o : (st_oe ? st_val : 1'b1);

   always #10 clock_50m = ~clock_50m;

   mdio_responder #(
      .PHY_ADDR    (MY_ADDR),
      .PREAMBLE_MIN(32),
      .SYNC_STAGES (2)
   ) dut (
      .clock_50m(clock_50m),
      .reset    (reset),
      .mdc      (mdc),
      .mdio_i   (mdio_pad),
      .mdio_o   (mdio_o),
      .mdio_oe  (mdio_oe),
      .reg_wr   (reg_wr),
      .reg_rd   (reg_rd),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata),
      .frame_err(frame_err)
   );

   // Event monitor: counts strobes and pad-drive cycles
   always @(negedge clock_50m) begin
      if (reg_wr) begin
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= reg_addr;
         last_wdata <= reg_wdata;
      end
      if (reg_rd) begin
         rd_cnt     <= rd_cnt + 1;
         last_raddr <= reg_addr;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (mdio_oe) oe_cycles <= oe_cycles + 1;
   end

   // Frame-level expectation from the Clause-22 rules
   function automatic int predict(input int pre_len, input logic [1:0] op,
                                  input logic [4:0] phyad, input logic [1:0] ta);
      if (pre_len < 32) return K_NONE;
      if (op != 2'b01 && op != 2'b10) return K_ERR;
      if (op == 2'b10) return (phyad == MY_ADDR) ? K_RD : K_NONE;
      if (phyad != MY_ADDR && !(BCAST && phyad == 5'd0)) return K_NONE;
      if (ta != 2'b10) return K_ERR;
      return K_WR;
   endfunction

   // One MDC period: low half (station drives), sample pad, then high half
   task automatic send_bit(input logic drive, input logic val, output logic smp);
      @(negedge clock_50m);
      mdc    = 1'b0;
      st_oe  = drive;
      st_val = val;
      repeat (HALF - 1) @(negedge clock_50m);
      smp = mdio_pad;
      @(negedge clock_50m);
      mdc = 1'b1;
      repeat (HALF - 1) @(negedge clock_50m);
   endtask

   // Leading 0 flushes any stale preamble count; abort_i >= 0 fires reset at that tail bit
   task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phyad,
                             input logic [4:0] regad, input logic [1:0] ta,
                             input logic [15:0] data, input int abort_i,
                             output logic [17:0] tail);
      logic        smp;
      logic [13:0] head;
      logic [17:0] tx;
      logic        rd;
      bit          aborted;
      rd      = (op == 2'b10);
      aborted = 1'b0;
      tail    = '1;
      send_bit(1'b1, 1'b0, smp);
      for (int i = 0; i < pre_len; i++) send_bit(1'b1, 1'b1, smp);
      head = {2'b01, op, phyad, regad};
      for (int i = 13; i >= 0; i--) send_bit(1'b1, head[i], smp);
      tx = {ta, data};
      for (int i = 17; i >= 0 && !aborted; i--) begin
         if (i == abort_i) begin
            @(negedge clock_50m);
            mdc   = 1'b0;
            st_oe = 1'b0;
            repeat (HALF - 1) @(negedge clock_50m);
            oe_before = mdio_oe;
            #3 reset = 1'b1;
            #1;
            oe_after = mdio_oe;
            o_after  = mdio_o;
            repeat (3) @(negedge clock_50m);
            reset   = 1'b0;
            aborted = 1'b1;
         end else begin
            send_bit(!rd, tx[i], smp);
            tail[i] = smp;
         end
      end
      if (!aborted) begin
         send_bit(1'b0, 1'b1, smp);
         send_bit(1'b0, 1'b1, smp);
      end
   endtask

   task automatic run_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phyad,
                            input logic [4:0] regad, input logic [1:0] ta,
                            input logic [15:0] data, input int abort_i,
                            output int dwr, output int drd, output int derr, output int doe,
                            output logic [17:0] tail);
      int wr0, rd0, er0, oe0;
      wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt; oe0 = oe_cycles;
      send_frame(pre_len, op, phyad, regad, ta, data, abort_i, tail);
      dwr  = wr_cnt - wr0;
      drd  = rd_cnt - rd0;
      derr = err_cnt - er0;
      doe  = oe_cycles - oe0;
   endtask

   task automatic test_reset();
      logic [26:0] got;
      repeat (5) @(negedge clock_50m);
      got = {mdio_o, mdio_oe, reg_wr, reg_rd, frame_err, reg_addr, reg_wdata};
      total++;
      if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0}) begin
         bad++;
         $display("FAIL reset_values got=%h want=%h", got, {1'b1, 26'd0});
      end
      reset = 1'b0;
      repeat (5) @(negedge clock_50m);
   endtask

   task automatic test_write();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      run_frame(32, 2'b01, 5'd1, 5'h1F, 2'b10, 16'h0005, -1, dwr, drd, derr, doe, tail);
      total++;
      if (dwr !== 1) begin bad++; $display("FAIL write_count got=%0d want=1", dwr); end
      total++;
      if (last_waddr !== 5'h1F) begin
         bad++; $display("FAIL write_addr got=%h want=1f", last_waddr);
      end
      total++;
      if (last_wdata !== 16'h0005) begin
         bad++; $display("FAIL write_data got=%h want=0005", last_wdata);
      end
      total++;
      if (doe !== 0 || derr !== 0) begin
         bad++; $display("FAIL write_quiet oe_cycles=%0d err=%0d want 0 0", doe, derr);
      end
   endtask

   task automatic test_read();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      reg_rdata = 16'h1340;
      run_frame(32, 2'b10, 5'd1, 5'h00, 2'b00, 16'h0000, -1, dwr, drd, derr, doe, tail);
      total++;
      if (drd !== 1 || last_raddr !== 5'h00) begin
         bad++; $display("FAIL read_request rd=%0d addr=%h want 1 00", drd, last_raddr);
      end
      total++;
      if (tail[17:16] !== 2'b10) begin
         bad++; $display("FAIL read_turnaround got=%b want=10", tail[17:16]);
      end
      total++;
      if (tail[15:0] !== 16'h1340) begin
         bad++; $display("FAIL read_data got=%h want=1340", tail[15:0]);
      end
      total++;
      if (doe !== OE_READ || mdio_oe !== 1'b0) begin
         bad++; $display("FAIL read_oe_window cycles=%0d oe_now=%b want %0d 0", doe, mdio_oe,
                         OE_READ);
      end
   endtask

   task automatic test_other_phy();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      run_frame(32, 2'b01, 5'd2, 5'h0D, 2'b10, 16'hFFFF, -1, dwr, drd, derr, doe, tail);
      total++;
      if (dwr !== 0 || derr !== 0 || doe !== 0) begin
         bad++; $display("FAIL other_phy wr=%0d err=%0d oe=%0d want 0 0 0", dwr, derr, doe);
      end
      run_frame(32, 2'b01, 5'd1, 5'h0D, 2'b10, 16'h4007, -1, dwr, drd, derr, doe, tail);
      total++;
      if (dwr !== 1 || last_waddr !== 5'h0D || last_wdata !== 16'h4007) begin
         bad++; $display("FAIL after_skip wr=%0d addr=%h data=%h want 1 0d 4007", dwr,
                         last_waddr, last_wdata);
      end
   endtask

   task automatic test_preamble();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      run_frame(31, 2'b01, 5'd1, 5'h03, 2'b10, 16'hA5A5, -1, dwr, drd, derr, doe, tail);
      total++;
      if (dwr !== 0 || derr !== 0) begin
         bad++; $display("FAIL short_preamble wr=%0d err=%0d want 0 0", dwr, derr);
      end
      run_frame(32, 2'b01, 5'd1, 5'h03, 2'b10, 16'hA5A5, -1, dwr, drd, derr, doe, tail);
      total++;
      if (dwr !== 1 || last_wdata !== 16'hA5A5) begin
         bad++; $display("FAIL full_preamble wr=%0d data=%h want 1 a5a5", dwr, last_wdata);
      end
   endtask

   task automatic test_errors();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      run_frame(32, 2'b00, 5'd1, 5'h04, 2'b10, 16'h1234, -1, dwr, drd, derr, doe, tail);
      total++;
      if (derr !== 1 || dwr !== 0 || drd !== 0) begin
         bad++; $display("FAIL bad_op err=%0d wr=%0d rd=%0d want 1 0 0", derr, dwr, drd);
      end
      run_frame(32, 2'b01, 5'd1, 5'h04, 2'b11, 16'h1234, -1, dwr, drd, derr, doe, tail);
      total++;
      if (derr !== 1 || dwr !== 0) begin
         bad++; $display("FAIL bad_ta err=%0d wr=%0d want 1 0", derr, dwr);
      end
   endtask

   task automatic test_reset_mid_read();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      logic [15:0] val;
      reg_rdata = 16'hBEEF;
      run_frame(32, 2'b10, 5'd1, 5'h07, 2'b00, 16'h0000, 8, dwr, drd, derr, doe, tail);
      total++;
      if (oe_before !== 1'b1 || oe_after !== 1'b0 || o_after !== 1'b1) begin
         bad++; $display("FAIL reset_mid_read oe_before=%b oe_after=%b o_after=%b want 1 0 1",
                         oe_before, oe_after, o_after);
      end
      val       = 16'($urandom);
      reg_rdata = val;
      run_frame(32, 2'b10, 5'd1, 5'h09, 2'b00, 16'h0000, -1, dwr, drd, derr, doe, tail);
      total++;
      if (drd !== 1 || tail !== {2'b10, val}) begin
         bad++; $display("FAIL read_after_reset rd=%0d got=%h want 1 %h", drd, tail,
                         {2'b10, val});
      end
   endtask

   task automatic test_broadcast();
      int dwr, drd, derr, doe;
      logic [17:0] tail;
      run_frame(32, 2'b01, 5'd0, 5'h00, 2'b10, 16'h1340, -1, dwr, drd, derr, doe, tail);
      total++;
      if (dwr !== (BCAST ? 1 : 0)) begin
         bad++; $display("FAIL broadcast_write wr=%0d want %0d", dwr, BCAST ? 1 : 0);
      end
      run_frame(32, 2'b10, 5'd0, 5'h00, 2'b00, 16'h0000, -1, dwr, drd, derr, doe, tail);
      total++;
      if (drd !== 0 || doe !== 0 || derr !== 0) begin
         bad++; $display("FAIL broadcast_read rd=%0d oe=%0d err=%0d want 0 0 0", drd, doe, derr);
      end
   endtask

   task automatic test_random();
      int dwr, drd, derr, doe, kind, pre_len;
      logic [17:0] tail;
      logic [1:0]  op, ta;
      logic [4:0]  phyad, regad;
      logic [15:0] data, rval;
      for (int n = 0; n < 20; n++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: phyad = 5'd0;
            1: phyad = 5'd1;
            2: phyad = 5'd2;
            default: phyad = 5'($urandom);
         endcase
         regad   = 5'($urandom);
         data    = 16'($urandom);
         rval    = 16'($urandom);
         ta      = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
         pre_len = ($urandom_range(0, 5) == 0) ? 31 : 32 + $urandom_range(0, 8);
         reg_rdata = rval;
         kind = predict(pre_len, op, phyad, ta);
         run_frame(pre_len, op, phyad, regad, ta, data, -1, dwr, drd, derr, doe, tail);
         total++;
         if (dwr !== (kind == K_WR ? 1 : 0) || drd !== (kind == K_RD ? 1 : 0) ||
             derr !== (kind == K_ERR ? 1 : 0) || doe !== (kind == K_RD ? OE_READ : 0)) begin
            bad++;
            $display("FAIL rand_outcome n=%0d got wr=%0d rd=%0d err=%0d oe=%0d want kind=%0d",
                     n, dwr, drd, derr, doe, kind);
         end
         if (kind == K_WR) begin
            total++;
            if (last_waddr !== regad || last_wdata !== data) begin
               bad++; $display("FAIL rand_write n=%0d got %h/%h want %h/%h", n, last_waddr,
                               last_wdata, regad, data);
            end
         end
         if (kind == K_RD) begin
            total++;
            if (last_raddr !== regad || tail !== {2'b10, rval}) begin
               bad++; $display("FAIL rand_read n=%0d got %h/%h want %h/%h", n, last_raddr,
                               tail, regad, {2'b10, rval});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_other_phy();
      test_preamble();
      test_errors();
      test_reset_mid_read();
      test_broadcast();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog against a stalled bench
   initial begin
      #5ms;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
